// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto the single 4-bank data memory,
// sequencing each access through the memory's one-cycle synchronous read.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_done,

    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_in,
    output logic              mem_wren,
    output logic [1:0]        mem_width,
    input  logic [31:0]       mem_out
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RWAIT,
        RESP,
        WDONE
    } state_t;

    state_t state, state_next;

    logic [SC_W-1:0]   starve_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [31:0]       lat_wdata;
    logic              lat_fetch;

    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;
    logic [31:0]       load_ext;
    logic [1:0]        width_enc;

    assign width_enc = lat_size[1] ? 2'b11 : lat_size;

    // State register only; everything the FSM drives is decoded below.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, next state and memory-side outputs. Reset masks every
    // output so that a store caught in ACCESS never reaches the memory.
    always_comb begin
        state_next  = state;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        if_rvalid   = 1'b0;
        d_rvalid    = 1'b0;
        d_done      = 1'b0;
        mem_address = '0;
        mem_in      = '0;
        mem_wren    = 1'b0;
        mem_width   = 2'b00;

        case (state)
            IDLE: begin
                if (if_req && d_req) begin
                    if (starve_cnt == STARVE_MAX) begin
                        if_gnt = 1'b1;
                    end else begin
                        d_gnt = 1'b1;
                    end
                end else if (if_req) begin
                    if_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end
                if (if_gnt || d_gnt) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_address = lat_addr;
                mem_in      = lat_wdata;
                mem_width   = width_enc;
                mem_wren    = lat_we;
                state_next  = lat_we ? WDONE : RWAIT;
            end
            RWAIT: begin
                mem_address = lat_addr;
                mem_in      = lat_wdata;
                mem_width   = width_enc;
                state_next  = RESP;
            end
            RESP: begin
                if (lat_fetch) begin
                    if_rvalid = 1'b1;
                end else begin
                    d_rvalid = 1'b1;
                end
                state_next = IDLE;
            end
            WDONE: begin
                d_done     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (reset) begin
            if_gnt      = 1'b0;
            d_gnt       = 1'b0;
            if_rvalid   = 1'b0;
            d_rvalid    = 1'b0;
            d_done      = 1'b0;
            mem_address = '0;
            mem_in      = '0;
            mem_wren    = 1'b0;
            mem_width   = 2'b00;
        end
    end

    // Memory returns the addressed byte in [31:24], so narrow loads take the top bits.
    always_comb begin
        load_ext = mem_out;
        case (lat_size)
            2'b00:   load_ext = {{24{~lat_unsigned & mem_out[31]}}, mem_out[31:24]};
            2'b01:   load_ext = {{16{~lat_unsigned & mem_out[31]}}, mem_out[31:16]};
            default: load_ext = mem_out;
        endcase
    end

    // Request capture and starvation tracking. A fetch is latched as a word load.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt   <= '0;
            lat_addr     <= '0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_wdata    <= '0;
            lat_fetch    <= 1'b0;
        end else if (if_gnt) begin
            starve_cnt   <= '0;
            lat_addr     <= if_addr;
            lat_we       <= 1'b0;
            lat_size     <= 2'b10;
            lat_unsigned <= 1'b1;
            lat_wdata    <= '0;
            lat_fetch    <= 1'b1;
        end else if (d_gnt) begin
            if (if_req) begin
                starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + SC_W'(1);
            end else begin
                starve_cnt <= '0;
            end
            lat_addr     <= d_addr;
            lat_we       <= d_we;
            lat_size     <= d_size;
            lat_unsigned <= d_unsigned;
            lat_wdata    <= d_wdata;
            lat_fetch    <= 1'b0;
        end
    end

    // Each port keeps its last completed load until the next one on that port.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (state == RWAIT) begin
            if (lat_fetch) begin
                if_rdata_q <= mem_out;
            end else begin
                d_rdata_q <= load_ext;
            end
        end
    end

    assign if_rdata = reset ? 32'h0 : if_rdata_q;
    assign d_rdata  = reset ? 32'h0 : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array memory, transaction-level latency/arbitration
// model checked every cycle, plus directed accesses with hand-computed results.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int AW    = 10;
    localparam int LIMIT = 4;
    localparam int MSIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [1:0]    d_size;
    logic          d_unsigned;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          d_done;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_in;
    logic          mem_wren;
    logic [1:0]    mem_width;
    logic [31:0]   mem_out;

    int nChecks = 0;
    int nPass   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_unsigned(d_unsigned), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_address(mem_address), .mem_in(mem_in), .mem_wren(mem_wren),
        .mem_width(mem_width), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    // Byte-addressed memory, big-endian lanes, synchronous read, wrapping addresses.
    logic [7:0] mem [0:MSIZE-1];
    always @(posedge clk) begin
        if (mem_wren) begin
            case (mem_width)
                2'b00: mem[mem_address] <= mem_in[7:0];
                2'b01: begin
                    mem[mem_address]              <= mem_in[15:8];
                    mem[AW'(mem_address + 10'd1)] <= mem_in[7:0];
                end
                default: begin
                    mem[mem_address]              <= mem_in[31:24];
                    mem[AW'(mem_address + 10'd1)] <= mem_in[23:16];
                    mem[AW'(mem_address + 10'd2)] <= mem_in[15:8];
                    mem[AW'(mem_address + 10'd3)] <= mem_in[7:0];
                end
            endcase
        end
        mem_out <= {mem[mem_address], mem[AW'(mem_address + 10'd1)],
                    mem[AW'(mem_address + 10'd2)], mem[AW'(mem_address + 10'd3)]};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference model state: one transaction in flight, described by its timing.
    logic [7:0]  refMem [0:MSIZE-1];
    int          cyc = 0;
    int          freeAt = 0;
    int          starveM = 0;
    bit          pendValid = 0;
    bit          pendFetch;
    bit          pendWe;
    bit          pendUns;
    logic [1:0]  pendSize;
    logic [AW-1:0] pendAddr;
    logic [31:0] pendWdata;
    logic [31:0] pendData;
    int          accAt;
    int          respAt;
    logic [31:0] lastIf = 0;
    logic [31:0] lastD = 0;

    function automatic int nBytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refLoad(input logic [AW-1:0] a, input logic [1:0] size, input bit uns);
        logic [31:0] w;
        int n;
        w = 0;
        n = nBytes(size);
        for (int k = 0; k < n; k++) begin
            w = (w << 8) | 32'(refMem[(int'(a) + k) % MSIZE]);
        end
        if (!uns && n < 4 && w[8*n-1]) begin
            w = w | (32'hFFFFFFFF << (8*n));
        end
        return w;
    endfunction

    always @(negedge clk) begin
        logic expIf, expD, expWren, expIfV, expDV, expDone;
        cyc++;
        if (reset) begin
            checkOutput("rst_ctrl", {26'b0, if_gnt, if_rvalid, d_gnt, d_rvalid, d_done, mem_wren}, 32'h0);
            checkOutput("rst_if_rdata", if_rdata, 32'h0);
            checkOutput("rst_d_rdata", d_rdata, 32'h0);
            checkOutput("rst_mem_bus", {20'b0, mem_address, mem_width} | mem_in, 32'h0);
            pendValid = 0;
            freeAt    = cyc + 1;
            starveM   = 0;
            lastIf    = 0;
            lastD     = 0;
        end else begin
            expIf = 0;
            expD  = 0;
            if (cyc >= freeAt) begin
                if (if_req && d_req) begin
                    if (starveM == LIMIT) expIf = 1; else expD = 1;
                end else if (if_req) begin
                    expIf = 1;
                end else if (d_req) begin
                    expD = 1;
                end
            end
            checkOutput("if_gnt", 32'(if_gnt), 32'(expIf));
            checkOutput("d_gnt", 32'(d_gnt), 32'(expD));

            expWren = pendValid && cyc == accAt && pendWe;
            checkOutput("mem_wren", 32'(mem_wren), 32'(expWren));
            if (pendValid && (cyc == accAt || (cyc == accAt + 1 && !pendWe))) begin
                checkOutput("mem_address", 32'(mem_address), 32'(pendAddr));
                checkOutput("mem_width", 32'(mem_width), (pendSize == 2'b00) ? 32'd0 : (pendSize == 2'b01) ? 32'd1 : 32'd3);
                if (pendWe) checkOutput("mem_in", mem_in, pendWdata);
            end
            if (pendValid && cyc == accAt) begin
                if (pendWe) begin
                    for (int k = 0; k < nBytes(pendSize); k++) begin
                        refMem[(int'(pendAddr) + k) % MSIZE] = 8'(pendWdata >> (8*(nBytes(pendSize) - 1 - k)));
                    end
                end else begin
                    pendData = refLoad(pendAddr, pendSize, pendUns);
                end
            end

            expIfV  = pendValid && cyc == respAt && pendFetch;
            expDV   = pendValid && cyc == respAt && !pendFetch && !pendWe;
            expDone = pendValid && cyc == respAt && pendWe;
            if (expIfV) lastIf = pendData;
            if (expDV)  lastD  = pendData;
            checkOutput("if_rvalid", 32'(if_rvalid), 32'(expIfV));
            checkOutput("d_rvalid", 32'(d_rvalid), 32'(expDV));
            checkOutput("d_done", 32'(d_done), 32'(expDone));
            checkOutput("if_rdata", if_rdata, lastIf);
            checkOutput("d_rdata", d_rdata, lastD);
            if (pendValid && cyc == respAt) pendValid = 0;

            if (expIf || expD) begin
                pendValid = 1;
                pendFetch = expIf;
                pendWe    = expD && d_we;
                pendAddr  = expIf ? if_addr : d_addr;
                pendSize  = expIf ? 2'b10 : d_size;
                pendUns   = expIf ? 1'b1 : d_unsigned;
                pendWdata = d_wdata;
                accAt     = cyc + 1;
                respAt    = cyc + (pendWe ? 2 : 3);
                freeAt    = cyc + (pendWe ? 3 : 4);
                if (expIf || !if_req) starveM = 0;
                else if (starveM < LIMIT) starveM++;
            end
        end
    end

    // Issues one request, waits for its grant and its completion pulse.
    task automatic applyStimulus(input bit fetch, input bit we, input logic [AW-1:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                                 output logic [31:0] data, output int lat);
        bit got;
        int n;
        @(posedge clk); #1;
        if (fetch) begin
            if_req = 1; if_addr = addr;
        end else begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_unsigned = uns;
        end
        got = 0;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (fetch ? if_gnt : d_gnt) got = 1; else n++;
        end
        checkOutput("gnt_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        if_req = 0;
        d_req  = 0;
        got = 0;
        lat = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (fetch ? if_rvalid : (we ? d_done : d_rvalid)) got = 1;
        end
        checkOutput("resp_seen", 32'(got), 32'd1);
        data = fetch ? if_rdata : d_rdata;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] data;
        int lat, doneSeen, rv, dg, n;
        logic [9:0] seq;
        logic [31:0] fetched;
        bit got;

        for (int i = 0; i < MSIZE; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            refMem[i] = 8'(i * 7 + 3);
        end
        reset = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_size = 0; d_unsigned = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        $display("[TB] store/load word");
        applyStimulus(0, 1, 10'h010, 32'hDEADBEEF, 2'b10, 0, data, lat);
        checkOutput("store_latency", 32'(lat), 32'd2);
        applyStimulus(0, 0, 10'h010, 0, 2'b10, 0, data, lat);
        checkOutput("load_latency", 32'(lat), 32'd3);
        checkOutput("load_word_010", data, 32'hDEADBEEF);

        $display("[TB] narrow loads");
        applyStimulus(0, 0, 10'h010, 0, 2'b00, 0, data, lat);
        checkOutput("load_byte_signed", data, 32'hFFFFFFDE);
        applyStimulus(0, 0, 10'h010, 0, 2'b00, 1, data, lat);
        checkOutput("load_byte_unsigned", data, 32'h000000DE);
        applyStimulus(0, 0, 10'h012, 0, 2'b01, 0, data, lat);
        checkOutput("load_half_signed", data, 32'hFFFFBEEF);

        $display("[TB] misaligned wrap");
        applyStimulus(0, 1, 10'h3FF, 32'h00001234, 2'b01, 0, data, lat);
        applyStimulus(0, 0, 10'h3FF, 0, 2'b01, 1, data, lat);
        checkOutput("load_half_3ff", data, 32'h00001234);
        applyStimulus(0, 0, 10'h3FC, 0, 2'b10, 0, data, lat);
        checkOutput("load_word_3fc", data, 32'hE7EEF512);
        applyStimulus(0, 0, 10'h000, 0, 2'b10, 0, data, lat);
        checkOutput("load_word_000", data, 32'h340A1118);

        $display("[TB] reset during store");
        @(posedge clk); #1;
        d_req = 1; d_we = 1; d_addr = 10'h020; d_wdata = 32'hFFFFFFFF; d_size = 2'b10; d_unsigned = 0;
        got = 0;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (d_gnt) got = 1; else n++;
        end
        checkOutput("rst_store_gnt", 32'(got), 32'd1);
        @(posedge clk); #1;
        d_req = 0;
        reset = 1;
        @(negedge clk);
        checkOutput("rst_wren_access", 32'(mem_wren), 32'd0);
        @(posedge clk); #1;
        reset = 0;
        doneSeen = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_done) doneSeen++;
        end
        checkOutput("rst_no_done", 32'(doneSeen), 32'd0);
        applyStimulus(0, 0, 10'h020, 0, 2'b10, 0, data, lat);
        checkOutput("load_word_020", data, 32'hE3EAF1F8);

        $display("[TB] starvation");
        @(posedge clk); #1;
        if_req = 1; if_addr = 10'h100;
        d_req = 1; d_we = 0; d_addr = 10'h040; d_size = 2'b10; d_unsigned = 0;
        seq = 0;
        n = 0;
        for (int k = 0; k < 100 && n < 10; k++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                seq = {seq[8:0], if_gnt};
                n++;
            end
        end
        @(posedge clk); #1;
        if_req = 0;
        d_req = 0;
        checkOutput("starve_seq", {22'b0, seq}, 32'h00000021);
        repeat (6) @(negedge clk);

        $display("[TB] data request during fetch RWAIT");
        @(posedge clk); #1;
        if_req = 1; if_addr = 10'h010;
        got = 0;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (if_gnt) got = 1; else n++;
        end
        checkOutput("fetch_gnt", 32'(got), 32'd1);
        @(posedge clk); #1;
        if_req = 0;
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = 10'h000; d_size = 2'b10; d_unsigned = 0;
        rv = -1;
        dg = -1;
        fetched = 0;
        for (int k = 0; k < 10 && dg < 0; k++) begin
            @(negedge clk);
            if (if_rvalid) begin
                rv = k;
                fetched = if_rdata;
            end
            if (d_gnt) dg = k;
        end
        @(posedge clk); #1;
        d_req = 0;
        checkOutput("rwait_gnt_cycle", 32'(dg), 32'd2);
        checkOutput("rwait_gnt_after_rvalid", 32'(dg - rv), 32'd1);
        checkOutput("fetch_data", fetched, 32'hDEADBEEF);
        got = 0;
        n = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (d_rvalid) got = 1;
        end
        checkOutput("rwait_load_seen", 32'(got), 32'd1);
        checkOutput("rwait_load_data", d_rdata, 32'h340A1118);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
